switch_debounce_trigger: RTL and testbench

//  Front-end stage of the manual counter datapath: conditions the raw sliding switch.
//  - Synchronises the asynchronous switch into clk.
//  - Debounces it with a stability-count state machine.
//  - Emits a single-cycle trigger pulse on each confirmed 1->0 transition ("switch goes down").
//  - The downstream counter consumes trigger as a count-enable strobe; the 7-seg encoder follows it.

---
 rtl/switch_debounce_trigger_pkg.sv | 17 +
 rtl/switch_debounce_trigger_sync_ff.sv | 25 ++
 rtl/switch_debounce_trigger.sv | 118 +++++++++++
 tb/tb_switch_debounce_trigger.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_trigger_pkg.sv
// Shared types for the switch debounce front end: FSM state encoding and reset helper.
package switch_debounce_trigger_pkg;

  // 2-bit encoding kept stable so downstream counter/encoder benches can decode it.
  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    ST_L2H  = 2'b01,
    ST_HIGH = 2'b10,
    ST_H2L  = 2'b11
  } state_e;

  // Stable state matching the level assumed at reset.
  function automatic state_e reset_state(input logic level);
    return level ? ST_HIGH : ST_LOW;
  endfunction

endpackage

// File: rtl/switch_debounce_trigger_sync_ff.sv
// Multi-flop synchroniser for the asynchronous switch input; flops reset to RESET_LEVEL.
module switch_debounce_trigger_sync_ff #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw level through the chain; the oldest flop is the synchronised output.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= {STAGES{RESET_LEVEL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/switch_debounce_trigger.sv
// Switch conditioner: synchronise, debounce with a stability-count FSM, and pulse
// trigger for one cycle on every confirmed 1->0 of the debounced level.
// Optional macro SWITCH_DEBOUNCE_RISE_EN adds trigger_rise, pulsing on confirmed 0->1.
module switch_debounce_trigger
  import switch_debounce_trigger_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sliding_switch,
  output logic switch_level,
  output logic trigger
`ifdef SWITCH_DEBOUNCE_RISE_EN
  ,
  output logic trigger_rise
`endif
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;
  logic             trigger_d;
`ifdef SWITCH_DEBOUNCE_RISE_EN
  logic             rise_d;
`endif

  switch_debounce_trigger_sync_ff #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sliding_switch),
    .q     (sync)
  );

  // State, stability counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= reset_state(RESET_LEVEL);
      cnt_q        <= '0;
      switch_level <= RESET_LEVEL;
      trigger      <= 1'b0;
`ifdef SWITCH_DEBOUNCE_RISE_EN
      trigger_rise <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      switch_level <= level_d;
      trigger      <= trigger_d;
`ifdef SWITCH_DEBOUNCE_RISE_EN
      trigger_rise <= rise_d;
`endif
    end
  end

  // Next state: any sample disagreeing with the pending level restarts the window.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    level_d   = switch_level;
    trigger_d = 1'b0;
`ifdef SWITCH_DEBOUNCE_RISE_EN
    rise_d    = 1'b0;
`endif
    unique case (state_q)
      ST_LOW: begin
        if (sync) begin
          state_d = ST_L2H;
          cnt_d   = CNT_ONE;
        end
      end
      ST_L2H: begin
        if (!sync) begin
          state_d = ST_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          level_d = 1'b1;
`ifdef SWITCH_DEBOUNCE_RISE_EN
          rise_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync) begin
          state_d = ST_H2L;
          cnt_d   = CNT_ONE;
        end
      end
      ST_H2L: begin
        if (sync) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_LOW;
          level_d   = 1'b0;
          trigger_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = reset_state(RESET_LEVEL);
      end
    endcase
  end

endmodule

// File: tb/tb_switch_debounce_trigger.sv
// Bench for switch_debounce_trigger: cycle scoreboard plus directed checks.
module tb_switch_debounce_trigger;
  import switch_debounce_trigger_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sliding_switch = 1'b0;
  logic switch_level;
  logic trigger;
`ifdef SWITCH_DEBOUNCE_RISE_EN
  logic trigger_rise;
`endif

  switch_debounce_trigger #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC),
    .RESET_LEVEL     (1'b0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sliding_switch (sliding_switch),
    .switch_level   (switch_level),
    .trigger        (trigger)
`ifdef SWITCH_DEBOUNCE_RISE_EN
    ,
    .trigger_rise   (trigger_rise)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: counts consecutive synced samples differing from the stable level.
  typedef struct packed {
    logic level;
    logic trig;
    logic rise;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            m_e;
  exp_t            o_e;
  logic [SYNC-1:0] m_sync;
  logic            m_stable;
  logic            m_s;
  int              m_run;

  always @(posedge clk) begin
    if (reset) begin
      m_sync   = '0;
      m_stable = 1'b0;
      m_run    = 0;
      m_e      = '0;
    end else begin
      m_s    = m_sync[SYNC-1];
      m_sync = {m_sync[SYNC-2:0], sliding_switch};
      m_e    = '0;
      if (m_s != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = m_s;
          m_run    = 0;
          m_e.trig = ~m_s;
          m_e.rise = m_s;
        end
      end else begin
        m_run = 0;
      end
      m_e.level = m_stable;
    end
    exp_q.push_back(m_e);
  end

  // Scoreboard compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      o_e = exp_q.pop_front();
      chk("sb_level", 32'(switch_level), 32'(o_e.level));
      chk("sb_trigger", 32'(trigger), 32'(o_e.trig));
`ifdef SWITCH_DEBOUNCE_RISE_EN
      chk("sb_trigger_rise", 32'(trigger_rise), 32'(o_e.rise));
`endif
    end
  end

  // Pulse counters, sampled just after the rising edge.
  int   trig_cnt = 0;
  int   rise_cnt = 0;
  int   consec   = 0;
  logic prev_trig = 1'b0;

  always @(posedge clk) begin
    #1;
    if (trigger === 1'b1) trig_cnt++;
    if (trigger === 1'b1 && prev_trig === 1'b1) consec++;
    prev_trig = trigger;
`ifdef SWITCH_DEBOUNCE_RISE_EN
    if (trigger_rise === 1'b1) rise_cnt++;
`endif
  end

  int t0;
  int r0;

  initial begin
    // 1: reset, switch low, hold idle
    repeat (3) @(negedge clk);
    chk("reset_level", 32'(switch_level), 32'd0);
    chk("reset_trigger", 32'(trigger), 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(ST_LOW));
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_state", 32'(dut.state_q), 32'(ST_LOW));
    chk("idle_level", 32'(switch_level), 32'd0);
    chk("idle_trig_cnt", 32'(trig_cnt), 32'd0);

    // 2: clean rise then clean fall, exact latency
    r0 = rise_cnt;
    sliding_switch = 1'b1;
    repeat (5) @(negedge clk);
    chk("rise_lat_before", 32'(switch_level), 32'd0);
    @(negedge clk);
    chk("rise_lat_at", 32'(switch_level), 32'd1);
    repeat (20) @(negedge clk);
    t0 = trig_cnt;
    sliding_switch = 1'b0;
    repeat (5) @(negedge clk);
    chk("fall_lat_before", 32'(trigger), 32'd0);
    @(negedge clk);
    chk("fall_lat_trig", 32'(trigger), 32'd1);
    chk("fall_lat_level", 32'(switch_level), 32'd0);
    @(negedge clk);
    chk("fall_trig_width", 32'(trigger), 32'd0);
    repeat (5) @(negedge clk);
    chk("clean_fall_cnt", 32'(trig_cnt - t0), 32'd1);
`ifdef SWITCH_DEBOUNCE_RISE_EN
    chk("clean_rise_cnt", 32'(rise_cnt - r0), 32'd1);
`endif

    // 3: from HIGH, five 3-cycle low glitches are all rejected
    sliding_switch = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_pre_level", 32'(switch_level), 32'd1);
    t0 = trig_cnt;
    for (int i = 0; i < 5; i++) begin
      sliding_switch = 1'b0;
      repeat (3) @(negedge clk);
      sliding_switch = 1'b1;
      repeat (5) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("glitch_level", 32'(switch_level), 32'd1);
    chk("glitch_trig_cnt", 32'(trig_cnt - t0), 32'd0);

    // 4: bouncing fall: 0 for 2, 1 for 1, then 0 held
    t0 = trig_cnt;
    sliding_switch = 1'b0;
    repeat (2) @(negedge clk);
    sliding_switch = 1'b1;
    @(negedge clk);
    sliding_switch = 1'b0;
    repeat (5) @(negedge clk);
    chk("bounce_trig_early", 32'(trigger), 32'd0);
    @(negedge clk);
    chk("bounce_trig_at", 32'(trigger), 32'd1);
    repeat (10) @(negedge clk);
    chk("bounce_trig_cnt", 32'(trig_cnt - t0), 32'd1);

    // 5: reset in H2L with cnt=2 discards the pending fall
    sliding_switch = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_pre_level", 32'(switch_level), 32'd1);
    t0 = trig_cnt;
    sliding_switch = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_state", 32'(dut.state_q), 32'(ST_H2L));
    chk("rst_mid_cnt", 32'(dut.cnt_q), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(dut.state_q), 32'(ST_LOW));
    chk("rst_level", 32'(switch_level), 32'd0);
    chk("rst_trigger", 32'(trigger), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_pulse", 32'(trig_cnt - t0), 32'd0);

    // 6: eight clean down-strokes
    t0 = trig_cnt;
    for (int i = 0; i < 8; i++) begin
      sliding_switch = 1'b1;
      repeat (8) @(negedge clk);
      sliding_switch = 1'b0;
      repeat (8) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("strokes_cnt", 32'(trig_cnt - t0), 32'd8);
    chk("strokes_consec", 32'(consec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
